// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART framing stage.
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_RESP,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: one synchronous write port, one combinational read port.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frames received bytes (AA, LEN, payload, XOR checksum), answers ACK/NAK,
// then streams the validated payload over valid/ready.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    input  logic       i_tx_active,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    output logic       o_pl_valid,
    output logic [7:0] o_pl_data,
    output logic       o_pl_last,
    input  logic       i_pl_ready,
    output logic [7:0] o_err_cnt
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int TIMEOUT_CYC  = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
    localparam int TMR_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

    state_t           state_reg;
    logic [7:0]       len_reg;
    logic [7:0]       xor_reg;
    logic [7:0]       idx_reg;
    logic [7:0]       rd_idx_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [7:0]       err_reg;
    logic             tx_dv_reg;
    logic [7:0]       tx_byte_reg;
    logic             pl_valid_reg;
    logic             ack_reg;

    logic       in_frame;
    logic       timeout_hit;
    logic       bad_len;
    logic       bad_chk;
    logic       dropped;
    logic       err_event;
    logic       last_beat;
    logic       buf_we;
    logic [7:0] buf_rd_data;

    always_comb begin
        in_frame    = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) || (state_reg == ST_CHK);
        // An arriving byte always beats an expiring timer.
        timeout_hit = in_frame && !i_rx_dv && (timer_reg == TMR_LAST);
        bad_len     = (state_reg == ST_LEN) && i_rx_dv &&
                      ((i_rx_byte == 8'd0) || (i_rx_byte > MAX_LEN_B));
        bad_chk     = (state_reg == ST_CHK) && i_rx_dv && (i_rx_byte != xor_reg);
        dropped     = ((state_reg == ST_RESP) || (state_reg == ST_DRAIN)) && i_rx_dv;
        err_event   = timeout_hit || bad_len || bad_chk || dropped;
        last_beat   = (rd_idx_reg == len_reg - 8'd1);
        buf_we      = (state_reg == ST_PAYLOAD) && i_rx_dv;
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (IDX_W)
    ) u_buf (
        .i_clk     (i_clk),
        .i_we      (buf_we),
        .i_wr_addr (idx_reg[IDX_W-1:0]),
        .i_wr_data (i_rx_byte),
        .i_rd_addr (rd_idx_reg[IDX_W-1:0]),
        .o_rd_data (buf_rd_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            len_reg      <= 8'd0;
            xor_reg      <= 8'd0;
            idx_reg      <= 8'd0;
            rd_idx_reg   <= 8'd0;
            timer_reg    <= '0;
            err_reg      <= 8'd0;
            tx_dv_reg    <= 1'b0;
            tx_byte_reg  <= 8'd0;
            pl_valid_reg <= 1'b0;
            ack_reg      <= 1'b0;
        end else begin
            tx_dv_reg <= 1'b0;
            if (err_event && (err_reg != 8'hFF)) begin
                err_reg <= err_reg + 8'd1;
            end
            if (in_frame) begin
                if (i_rx_dv || timeout_hit) begin
                    timer_reg <= '0;
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
                if (timeout_hit) begin
                    state_reg <= ST_IDLE;
                end
            end else begin
                timer_reg <= '0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) begin
                        state_reg <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_rx_dv) begin
                        len_reg <= i_rx_byte;
                        xor_reg <= i_rx_byte;
                        idx_reg <= 8'd0;
                        if (bad_len) begin
                            ack_reg <= 1'b0;
                            // Respond right away when the transmitter is free.
                            if (!i_tx_active) begin
                                tx_dv_reg   <= 1'b1;
                                tx_byte_reg <= NAK_BYTE;
                                state_reg   <= ST_IDLE;
                            end else begin
                                state_reg   <= ST_RESP;
                            end
                        end else begin
                            state_reg <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (i_rx_dv) begin
                        xor_reg <= xor_reg ^ i_rx_byte;
                        idx_reg <= idx_reg + 8'd1;
                        if (idx_reg + 8'd1 == len_reg) begin
                            state_reg <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (i_rx_dv) begin
                        ack_reg    <= !bad_chk;
                        rd_idx_reg <= 8'd0;
                        if (!i_tx_active) begin
                            tx_dv_reg   <= 1'b1;
                            tx_byte_reg <= bad_chk ? NAK_BYTE : ACK_BYTE;
                            state_reg   <= bad_chk ? ST_IDLE : ST_DRAIN;
                        end else begin
                            state_reg   <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (!i_tx_active) begin
                        tx_dv_reg   <= 1'b1;
                        tx_byte_reg <= ack_reg ? ACK_BYTE : NAK_BYTE;
                        state_reg   <= ack_reg ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // First DRAIN cycle only raises valid, so it trails the ACK pulse.
                    if (!pl_valid_reg) begin
                        pl_valid_reg <= 1'b1;
                    end else if (i_pl_ready) begin
                        if (last_beat) begin
                            pl_valid_reg <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end else begin
                            rd_idx_reg <= rd_idx_reg + 8'd1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_dv    = tx_dv_reg;
    assign o_tx_byte  = tx_byte_reg;
    assign o_pl_valid = pl_valid_reg;
    assign o_pl_data  = pl_valid_reg ? buf_rd_data : 8'd0;
    assign o_pl_last  = pl_valid_reg && last_beat;
    assign o_err_cnt  = err_reg;

endmodule
